// File: rtl/dlldel_code_ctrl.sv
// -----------------------------------------------------------------------------
// dlldel_code_ctrl
//
// Sequencing controller for one DLL delay element. Arbitrates between a
// calibration requester and a user/override requester, then slews the
// registered delay code one LSB at a time toward the granted target, holds a
// settle interval, and pulses o_done.
//
// Handshake: a requester raises i_*_req with a stable i_*_code and holds both
// until it sees its one-cycle o_*_gnt pulse. Requests are only considered in
// IDLE; while o_busy is high they wait. o_done pulses once per granted update.
//
// Ports:
//   i_clk       controller clock, rising edge
//   i_rstn      asynchronous active-low reset
//   i_cal_req   calibration request (held until o_cal_gnt)
//   i_cal_code  calibration target code
//   i_usr_req   user/override request (held until o_usr_gnt)
//   i_usr_code  user target code
//   i_freeze    pauses stepping and settle counting (grants still happen)
//   o_dcntl     registered delay code to the delay element (DCNTL)
//   o_cal_gnt   one-cycle pulse: calibration request accepted
//   o_usr_gnt   one-cycle pulse: user request accepted
//   o_busy      high in any state other than IDLE
//   o_done      one-cycle pulse: update complete and settled
//   o_owner     last-granted requester, 0 = cal, 1 = user
//   o_state     FSM state (0 IDLE, 1 SLEW, 2 SETTLE) for observation
// -----------------------------------------------------------------------------
module dlldel_code_ctrl #(
    parameter int                 CODE_W     = 6,
    parameter logic [CODE_W-1:0]  INIT_CODE  = '0,
    parameter int                 STEP_DIV   = 4,
    parameter int                 SETTLE_CYC = 8
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cal_req,
    input  logic [CODE_W-1:0] i_cal_code,
    input  logic              i_usr_req,
    input  logic [CODE_W-1:0] i_usr_code,
    input  logic              i_freeze,
    output logic [CODE_W-1:0] o_dcntl,
    output logic              o_cal_gnt,
    output logic              o_usr_gnt,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_owner,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SLEW   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Step fires when the counter already holds STEP_DIV-1, so the k-th step
    // lands exactly k*STEP_DIV edges after the grant edge.
    localparam logic [7:0] STEP_LAST   = 8'(STEP_DIV - 1);
    // SETTLE is entered one edge after the last step; finishing when the
    // counter holds SETTLE_CYC-2 puts DONE SETTLE_CYC edges after that step.
    localparam logic [7:0] SETTLE_LAST = (SETTLE_CYC > 1) ? 8'(SETTLE_CYC - 2) : 8'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CODE_W-1:0]   r_dcntl;
    logic [CODE_W-1:0]   r_tgt;
    logic [7:0]          r_cnt;
    logic                r_owner;
    logic                r_cal_gnt;
    logic                r_usr_gnt;
    logic                r_done;

    logic                w_at_tgt;
    logic                w_grant;
    logic                w_pick_usr;
    logic                w_step;
    logic                w_finish;
    logic [7:0]          w_cnt_nxt;

    assign w_at_tgt = (r_dcntl == r_tgt);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_cal_req || i_usr_req) w_state_nxt = ST_SLEW;
            end
            ST_SLEW: begin
                if (!i_freeze && w_at_tgt) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!i_freeze && (r_cnt == SETTLE_LAST)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs / strobes
    always_comb begin
        w_grant    = 1'b0;
        w_pick_usr = 1'b0;
        w_step     = 1'b0;
        w_finish   = 1'b0;
        w_cnt_nxt  = r_cnt;
        o_busy     = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                w_grant    = i_cal_req | i_usr_req;
                // On a tie the requester that did not win last time goes next.
                w_pick_usr = i_usr_req & (~i_cal_req | ~r_owner);
                w_cnt_nxt  = 8'd0;
            end
            ST_SLEW: begin
                if (!i_freeze) begin
                    if (w_at_tgt) begin
                        w_cnt_nxt = 8'd0;
                    end else if (r_cnt == STEP_LAST) begin
                        w_step    = 1'b1;
                        w_cnt_nxt = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            ST_SETTLE: begin
                if (!i_freeze) begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_finish  = 1'b1;
                        w_cnt_nxt = 8'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 8'd1;
                    end
                end
            end
            default: w_cnt_nxt = 8'd0;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_dcntl   <= INIT_CODE;
            r_tgt     <= INIT_CODE;
            r_cnt     <= 8'd0;
            r_owner   <= 1'b1;
            r_cal_gnt <= 1'b0;
            r_usr_gnt <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_finish;
            r_cal_gnt <= w_grant & ~w_pick_usr;
            r_usr_gnt <= w_grant &  w_pick_usr;
            if (w_grant) begin
                r_tgt   <= w_pick_usr ? i_usr_code : i_cal_code;
                r_owner <= w_pick_usr;
            end
            // Only ever moves toward the target, so no wrap and no overshoot.
            if (w_step) begin
                if (r_tgt > r_dcntl) begin
                    r_dcntl <= r_dcntl + CODE_W'(1);
                end else begin
                    r_dcntl <= r_dcntl - CODE_W'(1);
                end
            end
        end
    end

    assign o_dcntl   = r_dcntl;
    assign o_cal_gnt = r_cal_gnt;
    assign o_usr_gnt = r_usr_gnt;
    assign o_done    = r_done;
    assign o_owner   = r_owner;
    assign o_state   = r_state;

endmodule
